// File: rtl/wasm_run_ctrl_pkg.sv
// Shared state/status encodings and constants for the WASM run controller.
package wasm_run_ctrl_pkg;

  localparam int INSTR_LOG2_BRAM_DEPTH = 10;

  // Number of cycles the core is held in reset before RUN.
  localparam logic [1:0] RC_START_HOLD = 2'd2;

  typedef enum logic [2:0] {
    RC_IDLE  = 3'd0,
    RC_LOAD  = 3'd1,
    RC_START = 3'd2,
    RC_RUN   = 3'd3,
    RC_DONE  = 3'd4
  } rc_state_e;

  typedef enum logic [2:0] {
    RC_ST_NONE      = 3'd0,
    RC_ST_OK        = 3'd1,
    RC_ST_INSTR_ERR = 3'd2,
    RC_ST_STACK_OVF = 3'd3,
    RC_ST_TIMEOUT   = 3'd4,
    RC_ST_ABORT     = 3'd5
  } rc_status_e;

endpackage

// File: rtl/wasm_ibram_loader.sv
// Streams host words into instruction BRAM through a registered write port,
// accepting exactly len words in address order.
module wasm_ibram_loader #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    len,
  input  logic               abort,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               ibram_we,
  output logic [ADDR_W-1:0]  ibram_addr,
  output logic [INSTR_W-1:0] ibram_wdata,
  output logic               last
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] len_q;
  logic            hs;
  logic            final_word;

  // An abort in the same cycle as a valid word wins: the word is dropped.
  assign hs         = load_valid & load_ready & ~abort;
  assign final_word = (cnt_q + CNT_ONE) == len_q;
  assign last       = (len_q == '0) | (hs & final_word);

  // NOTE: sequential state uses non-blocking assignments, and the write
  // port is reset asynchronously so no write survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= '0;
      load_ready  <= 1'b0;
      ibram_we    <= 1'b0;
      ibram_addr  <= '0;
      ibram_wdata <= '0;
    end else begin
      ibram_we <= hs;
      if (hs) begin
        ibram_addr  <= cnt_q[ADDR_W-1:0];
        ibram_wdata <= load_data;
        cnt_q       <= cnt_q + CNT_ONE;
      end
      if (start) begin
        cnt_q      <= '0;
        len_q      <= len;
        load_ready <= (len != '0);
      end else if (abort || (hs && final_word)) begin
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wasm_run_ctrl.sv
// Run controller for the WASM stack core: program load, core reset
// sequencing, cycle counting and watchdog.
module wasm_run_ctrl
  import wasm_run_ctrl_pkg::*;
#(
  parameter int ADDR_W  = INSTR_LOG2_BRAM_DEPTH,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load_start,
  input  logic [ADDR_W:0]    i_load_len,
  input  logic               i_load_valid,
  input  logic [INSTR_W-1:0] i_load_data,
  output logic               o_load_ready,
  input  logic               i_run_start,
  input  logic               i_abort,
  input  logic [CNT_W-1:0]   i_timeout_limit,
  output logic               o_ibram_we,
  output logic [ADDR_W-1:0]  o_ibram_addr,
  output logic [INSTR_W-1:0] o_ibram_wdata,
  output logic               o_core_rst,
  input  logic               i_core_finish,
  input  logic               i_core_instr_error,
  input  logic               i_core_stack_full,
  output logic               o_busy,
  output logic               o_done,
  output logic [2:0]         o_status,
  output logic [CNT_W-1:0]   o_cycle_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rc_state_e        state_q, state_d;
  rc_status_e       status_q, status_d;
  logic [1:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_go;
  logic             load_abort;
  logic             load_last;
  logic             timeout_hit;

  assign load_abort  = i_abort & (state_q == RC_LOAD);
  assign timeout_hit = (i_timeout_limit != '0) && (cnt_q == i_timeout_limit);

  wasm_ibram_loader #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_loader (
    .clk        (i_clk),
    .rst        (i_rst),
    .start      (load_go),
    .len        (i_load_len),
    .abort      (load_abort),
    .load_valid (i_load_valid),
    .load_data  (i_load_data),
    .load_ready (o_load_ready),
    .ibram_we   (o_ibram_we),
    .ibram_addr (o_ibram_addr),
    .ibram_wdata(o_ibram_wdata),
    .last       (load_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= RC_IDLE;
      status_q <= RC_ST_NONE;
      hold_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every value written here gets its default first, so no latch is
  // inferred on paths that leave it untouched.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    load_go  = 1'b0;
    unique case (state_q)
      RC_IDLE, RC_DONE: begin
        if (i_load_start) begin
          load_go = 1'b1;
          state_d = RC_LOAD;
        end else if (i_run_start) begin
          state_d  = RC_START;
          hold_d   = '0;
          cnt_d    = '0;
          status_d = RC_ST_NONE;
        end
      end
      RC_LOAD: begin
        if (i_abort) begin
          state_d  = RC_DONE;
          status_d = RC_ST_ABORT;
        end else if (load_last) begin
          state_d = RC_IDLE;
        end
      end
      RC_START: begin
        // Core flags are meaningless while the core sits in reset.
        if (i_abort) begin
          state_d  = RC_DONE;
          status_d = RC_ST_ABORT;
        end else if (hold_q == RC_START_HOLD - 2'd1) begin
          state_d = RC_RUN;
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end
      RC_RUN: begin
        state_d = RC_DONE;
        if (i_abort)                 status_d = RC_ST_ABORT;
        else if (i_core_instr_error) status_d = RC_ST_INSTR_ERR;
        else if (i_core_stack_full)  status_d = RC_ST_STACK_OVF;
        else if (i_core_finish)      status_d = RC_ST_OK;
        else if (timeout_hit)        status_d = RC_ST_TIMEOUT;
        else begin
          state_d = RC_RUN;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = RC_IDLE;
    endcase
  end

  assign o_core_rst  = (state_q != RC_RUN);
  assign o_busy      = (state_q == RC_LOAD) || (state_q == RC_START) || (state_q == RC_RUN);
  assign o_done      = (state_q == RC_DONE);
  assign o_status    = status_q;
  assign o_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_wasm_run_ctrl.sv
// Self-checking bench for wasm_run_ctrl: randomized loads and runs checked
// against a behavioural model of the load and run rules.
module tb_wasm_run_ctrl;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = ADDR_W + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               i_load_start = 1'b0;
  logic [LEN_W-1:0]   i_load_len = '0;
  logic               i_load_valid = 1'b0;
  logic [INSTR_W-1:0] i_load_data = '0;
  logic               o_load_ready;
  logic               i_run_start = 1'b0;
  logic               i_abort = 1'b0;
  logic [CNT_W-1:0]   i_timeout_limit = '0;
  logic               o_ibram_we;
  logic [ADDR_W-1:0]  o_ibram_addr;
  logic [INSTR_W-1:0] o_ibram_wdata;
  logic               o_core_rst;
  logic               i_core_finish = 1'b0;
  logic               i_core_instr_error = 1'b0;
  logic               i_core_stack_full = 1'b0;
  logic               o_busy;
  logic               o_done;
  logic [2:0]         o_status;
  logic [CNT_W-1:0]   o_cycle_cnt;

  wasm_run_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_load_start(i_load_start), .i_load_len(i_load_len),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data), .o_load_ready(o_load_ready),
    .i_run_start(i_run_start), .i_abort(i_abort), .i_timeout_limit(i_timeout_limit),
    .o_ibram_we(o_ibram_we), .o_ibram_addr(o_ibram_addr), .o_ibram_wdata(o_ibram_wdata),
    .o_core_rst(o_core_rst), .i_core_finish(i_core_finish),
    .i_core_instr_error(i_core_instr_error), .i_core_stack_full(i_core_stack_full),
    .o_busy(o_busy), .o_done(o_done), .o_status(o_status), .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit saw_run = 1'b0;

  typedef struct { int addr; logic [INSTR_W-1:0] data; int cyc; } wr_t;
  wr_t wr_log[$];
  int  hs_cyc[$];
  logic [INSTR_W-1:0] words [64];
  logic [3:0] run_flags [1024];  // {abort, instr_error, stack_full, finish} per RUN cycle

  typedef struct { int ran; bit ended; logic [2:0] status; logic [CNT_W-1:0] cnt; } run_exp_t;
  typedef struct {
    int ran;
    logic start_rst, run0_rst, pre_done, done, core_rst, busy;
    logic [2:0] status, start_status;
    logic [CNT_W-1:0] cnt, start_cnt;
  } run_obs_t;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_ibram_we === 1'b1)
      wr_log.push_back('{addr: int'(o_ibram_addr), data: o_ibram_wdata, cyc: cyc});
    if (o_core_rst === 1'b0) saw_run = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Expected run outcome from the termination rules, walking RUN cycles.
  function automatic run_exp_t run_model(input int limit, input int n);
    run_exp_t r;
    int cnt = 0;
    int ev;
    r.ended = 1'b0; r.status = 3'd0; r.ran = n;
    for (int k = 0; k < n; k++) begin
      if (run_flags[k][3])                      ev = 5;
      else if (run_flags[k][2])                 ev = 2;
      else if (run_flags[k][1])                 ev = 3;
      else if (run_flags[k][0])                 ev = 1;
      else if (limit != 0 && cnt == limit)      ev = 4;
      else                                      ev = 0;
      if (ev != 0) begin
        r.ended = 1'b1; r.status = 3'(ev); r.cnt = CNT_W'(cnt); r.ran = k + 1;
        return r;
      end
      if (cnt < CNT_MAX) cnt++;
    end
    r.cnt = CNT_W'(cnt);
    return r;
  endfunction

  task automatic run_seq(input int limit, input int n, output run_obs_t o);
    i_timeout_limit = CNT_W'(limit);
    i_run_start = 1'b1; tick(); i_run_start = 1'b0;
    o.start_rst = o_core_rst; o.start_status = o_status; o.start_cnt = o_cycle_cnt;
    for (int s = 0; s < 2; s++) begin
      {i_core_instr_error, i_core_stack_full, i_core_finish} = 3'($urandom);
      tick();
    end
    o.run0_rst = o_core_rst;
    o.pre_done = 1'b0;
    o.ran = 0;
    for (int k = 0; k < n; k++) begin
      {i_abort, i_core_instr_error, i_core_stack_full, i_core_finish} = run_flags[k];
      o.pre_done = o_done;
      o.ran = k + 1;
      tick();
      if (o_done === 1'b1) break;
    end
    {i_abort, i_core_instr_error, i_core_stack_full, i_core_finish} = 4'b0;
    o.done = o_done; o.core_rst = o_core_rst; o.busy = o_busy;
    o.status = o_status; o.cnt = o_cycle_cnt;
  endtask

  // mode: 0 valid always high, 1 valid toggling, 2 random valid.
  task automatic load_seq(input int len, input int mode, input int abort_after, input bit also_run);
    int idx = 0;
    int budget = 300;
    bit phase = 1'b1;
    bit v, hs;
    wr_log.delete(); hs_cyc.delete();
    i_load_len = LEN_W'(len);
    i_load_start = 1'b1; i_run_start = also_run;
    start_cyc = cyc;
    tick();
    i_load_start = 1'b0; i_run_start = 1'b0;
    while (idx < len && budget > 0) begin
      if (abort_after >= 0 && idx == abort_after) begin
        i_abort = 1'b1; i_load_valid = 1'b1; i_load_data = words[idx];
        tick();
        i_abort = 1'b0;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       begin v = phase; phase = ~phase; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      i_load_valid = v;
      i_load_data  = v ? words[idx] : 32'($urandom);
      hs = v && (o_load_ready === 1'b1);
      if (hs) hs_cyc.push_back(cyc);
      tick();
      if (hs) idx++;
      budget--;
    end
    for (int i = 0; i < 3; i++) begin
      i_load_valid = 1'b1; i_load_data = 32'($urandom);
      tick();
    end
    i_load_valid = 1'b0;
    tick();
  endtask

  task automatic check_writes(input string name, input int n);
    vectors++;
    if (wr_log.size() !== n) begin
      miscompares++;
      $display("FAIL %s write count: got %0d, want %0d", name, wr_log.size(), n);
    end
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      vectors++;
      if (wr_log[i].addr !== i || wr_log[i].data !== words[i]) begin
        miscompares++;
        $display("FAIL %s write %0d: got addr %0d data %h, want addr %0d data %h",
                 name, i, wr_log[i].addr, wr_log[i].data, i, words[i]);
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({o_core_rst, o_load_ready, o_ibram_we, o_busy, o_done} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset flags: got %b, want 10000",
               {o_core_rst, o_load_ready, o_ibram_we, o_busy, o_done});
    end
    vectors++;
    if (o_ibram_addr !== '0 || o_ibram_wdata !== '0 || o_status !== 3'd0 || o_cycle_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset values: got addr %h wdata %h status %0d cnt %0d, want all 0",
               o_ibram_addr, o_ibram_wdata, o_status, o_cycle_cnt);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_load_burst();
    for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
    load_seq(4, 0, -1, 1'b0);
    check_writes("burst", 4);
    for (int i = 0; i < wr_log.size(); i++) begin
      vectors++;
      if (wr_log[i].cyc !== start_cyc + 2 + i) begin
        miscompares++;
        $display("FAIL burst timing %0d: got cycle %0d, want %0d", i, wr_log[i].cyc, start_cyc + 2 + i);
      end
    end
    vectors++;
    if ({o_load_ready, o_busy, o_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL burst end state: got ready/busy/done %b, want 000", {o_load_ready, o_busy, o_done});
    end
  endtask

  task automatic test_load_toggle();
    for (int i = 0; i < 3; i++) words[i] = 32'($urandom);
    load_seq(3, 1, -1, 1'b0);
    check_writes("toggle", 3);
    for (int i = 0; i < wr_log.size() && i < hs_cyc.size(); i++) begin
      vectors++;
      if (wr_log[i].cyc !== hs_cyc[i] + 1) begin
        miscompares++;
        $display("FAIL toggle latency %0d: got cycle %0d, want %0d", i, wr_log[i].cyc, hs_cyc[i] + 1);
      end
    end
  endtask

  task automatic test_load_random();
    int len;
    for (int it = 0; it < 6; it++) begin
      len = (it == 0) ? 32 : (it == 1) ? 0 : int'($urandom_range(1, 31));
      for (int i = 0; i < 64; i++) words[i] = 32'($urandom);
      load_seq(len, 2, -1, 1'b0);
      check_writes("random load", len);
      vectors++;
      if ({o_load_ready, o_busy, o_done} !== 3'b000) begin
        miscompares++;
        $display("FAIL random load end len=%0d: got ready/busy/done %b, want 000",
                 len, {o_load_ready, o_busy, o_done});
      end
    end
  endtask

  task automatic test_run_finish();
    run_exp_t e;
    run_obs_t o;
    for (int k = 0; k < 1024; k++) run_flags[k] = 4'b0;
    run_flags[10] = 4'b0001;
    e = run_model(0, 40);
    run_seq(0, 40, o);
    vectors++;
    if ({o.start_rst, o.start_status, o.start_cnt} !== {1'b1, 3'd0, CNT_W'(0)}) begin
      miscompares++;
      $display("FAIL finish START: got rst %b status %0d cnt %0d, want 1 0 0", o.start_rst, o.start_status, o.start_cnt);
    end
    vectors++;
    if (o.run0_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL finish first RUN core_rst: got %b, want 0", o.run0_rst);
    end
    vectors++;
    if (o.ran !== e.ran || o.pre_done !== 1'b0 || o.done !== 1'b1 || o.core_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL finish timing: got ran %0d pre_done %b done %b core_rst %b, want ran %0d 0 1 1",
               o.ran, o.pre_done, o.done, o.core_rst, e.ran);
    end
    vectors++;
    if (o.status !== e.status || o.cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL finish result: got status %0d cnt %0d, want %0d %0d", o.status, o.cnt, e.status, e.cnt);
    end
  endtask

  task automatic test_timeout();
    run_exp_t e;
    run_obs_t o;
    for (int k = 0; k < 1024; k++) run_flags[k] = 4'b0;
    e = run_model(5, 40);
    run_seq(5, 40, o);
    vectors++;
    if (o.done !== 1'b1 || o.status !== e.status || o.cnt !== e.cnt || o.ran !== e.ran) begin
      miscompares++;
      $display("FAIL timeout 5: got done %b status %0d cnt %0d ran %0d, want 1 %0d %0d %0d",
               o.done, o.status, o.cnt, o.ran, e.status, e.cnt, e.ran);
    end
    e = run_model(0, 1000);
    run_seq(0, 1000, o);
    vectors++;
    if (o.done !== 1'b0 || o.busy !== 1'b1 || o.cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL no-timeout: got done %b busy %b cnt %0d, want 0 1 %0d", o.done, o.busy, o.cnt, e.cnt);
    end
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    vectors++;
    if (o_done !== 1'b1 || o_status !== 3'd5 || o_cycle_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL abort run: got done %b status %0d cnt %0d, want 1 5 %0d", o_done, o_status, o_cycle_cnt, e.cnt);
    end
    for (int s = 0; s < 3; s++) begin
      {i_core_instr_error, i_core_stack_full, i_core_finish} = 3'b111;
      tick();
    end
    {i_core_instr_error, i_core_stack_full, i_core_finish} = 3'b000;
    vectors++;
    if (o_done !== 1'b1 || o_core_rst !== 1'b1 || o_status !== 3'd5 || o_cycle_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL DONE sticky: got done %b core_rst %b status %0d cnt %0d, want 1 1 5 %0d",
               o_done, o_core_rst, o_status, o_cycle_cnt, e.cnt);
    end
  endtask

  task automatic test_priority();
    run_exp_t e;
    run_obs_t o;
    int lim;
    for (int it = 0; it < 7; it++) begin
      for (int k = 0; k < 1024; k++) run_flags[k] = 4'b0;
      if (it == 0) begin
        lim = 0;
        run_flags[3] = 4'b0101;
      end else begin
        lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
        for (int k = 0; k < 60; k++)
          if ($urandom_range(0, 19) == 0) run_flags[k] = 4'($urandom_range(1, 15));
      end
      run_flags[59] = run_flags[59] | 4'b1000;
      e = run_model(lim, 60);
      run_seq(lim, 60, o);
      vectors++;
      if (o.done !== 1'b1 || o.status !== e.status || o.cnt !== e.cnt || o.ran !== e.ran) begin
        miscompares++;
        $display("FAIL priority run %0d: got done %b status %0d cnt %0d ran %0d, want 1 %0d %0d %0d",
                 it, o.done, o.status, o.cnt, o.ran, e.status, e.cnt, e.ran);
      end
    end
  endtask

  task automatic test_load_abort();
    for (int i = 0; i < 6; i++) words[i] = 32'($urandom);
    load_seq(6, 0, 2, 1'b0);
    check_writes("load abort", 2);
    vectors++;
    if ({o_done, o_load_ready, o_busy} !== 3'b100 || o_status !== 3'd5) begin
      miscompares++;
      $display("FAIL load abort state: got done/ready/busy %b status %0d, want 100 5",
               {o_done, o_load_ready, o_busy}, o_status);
    end
  endtask

  task automatic test_back_to_back();
    saw_run = 1'b0;
    for (int i = 0; i < 2; i++) words[i] = 32'($urandom);
    load_seq(2, 0, -1, 1'b1);
    check_writes("load wins", 2);
    vectors++;
    if (saw_run !== 1'b0 || {o_busy, o_done} !== 2'b00 || o_status !== 3'd5) begin
      miscompares++;
      $display("FAIL load wins: got ran %b busy/done %b status %0d, want 0 00 5",
               saw_run, {o_busy, o_done}, o_status);
    end
  endtask

  task automatic test_reset_mid();
    run_exp_t e;
    run_obs_t o;
    for (int i = 0; i < 8; i++) words[i] = 32'($urandom);
    wr_log.delete();
    i_load_len = LEN_W'(8);
    i_load_start = 1'b1; tick(); i_load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_load_valid = 1'b1; i_load_data = words[i]; tick();
    end
    i_load_data = words[2];
    @(posedge i_clk); #1;
    vectors++;
    if (o_ibram_we !== 1'b1) begin
      miscompares++;
      $display("FAIL mid-load write pending: got we %b, want 1", o_ibram_we);
    end
    i_rst = 1'b1; #1;
    vectors++;
    if ({o_ibram_we, o_load_ready, o_busy, o_core_rst} !== 4'b0001 || o_ibram_addr !== '0) begin
      miscompares++;
      $display("FAIL mid-load reset: got we/ready/busy/core_rst %b addr %0d, want 0001 0",
               {o_ibram_we, o_load_ready, o_busy, o_core_rst}, o_ibram_addr);
    end
    i_load_valid = 1'b0;
    tick(); i_rst = 1'b0; tick();
    check_writes("mid-load reset", 2);

    for (int k = 0; k < 1024; k++) run_flags[k] = 4'b0;
    run_seq(0, 20, o);
    #2 i_rst = 1'b1; #1;
    vectors++;
    if ({o_core_rst, o_busy, o_done} !== 3'b100 || o_status !== 3'd0 || o_cycle_cnt !== '0) begin
      miscompares++;
      $display("FAIL mid-run reset: got core_rst/busy/done %b status %0d cnt %0d, want 100 0 0",
               {o_core_rst, o_busy, o_done}, o_status, o_cycle_cnt);
    end
    tick(); i_rst = 1'b0; tick();
    run_flags[4] = 4'b0001;
    e = run_model(0, 20);
    run_seq(0, 20, o);
    vectors++;
    if (o.done !== 1'b1 || o.status !== e.status || o.cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL run after reset: got done %b status %0d cnt %0d, want 1 %0d %0d",
               o.done, o.status, o.cnt, e.status, e.cnt);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_load_burst();
    test_load_toggle();
    test_load_random();
    test_run_finish();
    test_timeout();
    test_priority();
    test_load_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
